gecko_mem_arbiter: RTL
======================

# gecko_mem_arbiter

Shares one `mem_intf` memory port between two requesters: port 0 (execute-stage data requests) and port 1 (fetch-stage instruction requests). It grants requests round-robin and locks each grant until its handshake completes. A tag FIFO records which requester issued each read, so read responses return in order to the port that asked for them. It sits between `gecko_execute` / fetch and the shared memory or cache port.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data width; write-enable mask is `DATA_WIDTH/8` bits
- `ADDR_WIDTH`, 32, address width
- `MAX_OUTSTANDING`, 4, tag FIFO depth (max reads in flight); power of two, ≥2

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0`  in  mem_intf(DATA_WIDTH, ADDR_WIDTH)  requester 0 (data); valid/ready, read_enable, write_enable mask, addr, data
- `req1`  in  mem_intf(DATA_WIDTH, ADDR_WIDTH)  requester 1 (instruction)
- `mem_out`  out  mem_intf(DATA_WIDTH, ADDR_WIDTH)  shared request to memory
- `mem_resp`  in  mem_intf(DATA_WIDTH, ADDR_WIDTH)  read responses from memory (valid/ready/data)
- `resp0`  out  mem_intf(DATA_WIDTH, ADDR_WIDTH)  read responses to requester 0
- `resp1`  out  mem_intf(DATA_WIDTH, ADDR_WIDTH)  read responses to requester 1
- `error`  out  1  sticky: response arrived with tag FIFO empty

## Operation
Request types:
- Read: `read_enable`=1. Pushes the owner tag (0/1) into the tag FIFO on handshake.
- Write: `write_enable`≠0. No response and no tag.

Arbitration:
- State: `last_grant` (1b), `locked` (1b), `lock_owner` (1b).
- When not locked, pick an eligible valid requester. If both are eligible, pick the one that is not `last_grant`. If one is eligible, pick it.
- Eligibility: a read is eligible only if tag count < `MAX_OUTSTANDING`. Writes are always eligible.
- Mux: `mem_out` carries the granted requester's payload and valid. Only the granted port sees `mem_out.ready`; the other port sees ready=0.
- If the grant is presented and `mem_out.ready`=0, set `locked`=1 and hold `lock_owner`. While locked, the grant does not change.
- The lock clears on handshake. `last_grant` updates on every `mem_out` handshake.

Response routing:
- FIFO head tag selects the destination: `respN.valid` = `mem_resp.valid` and head==N; `mem_resp.ready` = selected `respN.ready`.
- The FIFO pops on `mem_resp` handshake.
- Tag FIFO empty and `mem_resp.valid`=1: `mem_resp.ready`=1, data dropped, `error` set.

Count rules:
- `count` is `$clog2(MAX_OUTSTANDING)+1` bits; push/pop pointers wrap modulo `MAX_OUTSTANDING`.
- Simultaneous push and pop leaves count unchanged.
- Eligibility uses the registered count only. A pop in the same cycle does not free a slot for a read until the next cycle.

Reset values:
- `mem_out.valid`=0; `resp0.valid`=0, `resp1.valid`=0; `error`=0.
- count=0, pointers=0, `locked`=0, `last_grant`=1 (so port 0 wins the first tie).

Reset mid-operation:
- All state clears.
- In-flight responses arriving after reset hit an empty FIFO, are dropped, and set `error`.

## Timing
- Request path is combinational: zero added latency; `mem_out.valid` can rise in the same cycle as `reqN.valid`.
- Response path is combinational: zero latency from `mem_resp` to `respN`.
- Grant, lock and FIFO state update on the clock edge after the handshake.
- Payload stability: while locked, `mem_out` payload equals the locked requester's payload. Requesters must hold payload while valid && !ready, per the stream convention.
- Back-to-back: one handshake per cycle max. Alternating grants give each requester 50% throughput under contention.
- Full FIFO with pending read: the read stalls; a write on the other port is granted in the same cycle.

## Configuration
- `GECKO_MEM_ARBITER_FIXED_PRIORITY_EN` defined: req0 wins every tie (fixed priority; data over fetch); `last_grant` is unused. Lock behaviour is unchanged.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Tie arbitration: both ports issue reads every cycle, `mem_out.ready`=1 → grants alternate 0,1,0,1; responses with data 0xA0,0xB1,0xA2,0xB3 route to resp0,resp1,resp0,resp1.
- Lock hold: req1 read granted, `mem_out.ready`=0 for 3 cycles, req0 valid throughout → `mem_out.addr` stays req1's address; req0 is granted the cycle after the handshake.
- FIFO full, `MAX_OUTSTANDING`=4: 4 reads issued, no responses; 5th read on req0 → stalls (`req0.ready`=0); a req1 write is granted the same cycle; after one response pop, the read is granted next cycle.
- Orphan response: `mem_resp.valid`=1 with empty FIFO → `mem_resp.ready`=1, no `respN.valid`, `error`=1 held until `rst`.
- Response backpressure: head tag=0, `resp0.ready`=0 for 2 cycles → `mem_resp.ready`=0 and count unchanged; pop occurs when `resp0.ready`=1.
- Reset mid-op: 2 reads outstanding, assert `rst` async → `mem_out.valid`=0 and count=0 immediately; with `GECKO_MEM_ARBITER_FIXED_PRIORITY_EN` defined, a subsequent tie grants req0 twice in a row.

Source files
------------

// File: rtl/gecko_mem_arbiter.sv
// ============================================================================
// Module   : gecko_mem_arbiter
// Purpose  : Two-port memory request arbiter with lock-until-handshake grants
//            and an in-order tag FIFO that routes read responses back.
//            Optional: GECKO_MEM_ARBITER_FIXED_PRIORITY_EN (req0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gecko_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic                      req0_read_enable,
  input  logic [DATA_WIDTH/8-1:0]   req0_write_enable,
  input  logic [ADDR_WIDTH-1:0]     req0_addr,
  input  logic [DATA_WIDTH-1:0]     req0_data,

  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic                      req1_read_enable,
  input  logic [DATA_WIDTH/8-1:0]   req1_write_enable,
  input  logic [ADDR_WIDTH-1:0]     req1_addr,
  input  logic [DATA_WIDTH-1:0]     req1_data,

  output logic                      mem_out_valid,
  input  logic                      mem_out_ready,
  output logic                      mem_out_read_enable,
  output logic [DATA_WIDTH/8-1:0]   mem_out_write_enable,
  output logic [ADDR_WIDTH-1:0]     mem_out_addr,
  output logic [DATA_WIDTH-1:0]     mem_out_data,

  input  logic                      mem_resp_valid,
  output logic                      mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]     mem_resp_data,

  output logic                      resp0_valid,
  input  logic                      resp0_ready,
  output logic [DATA_WIDTH-1:0]     resp0_data,

  output logic                      resp1_valid,
  input  logic                      resp1_ready,
  output logic [DATA_WIDTH-1:0]     resp1_data,

  output logic                      error
);

  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);

  logic                       r_locked;
  logic                       r_lock_owner;
`ifndef GECKO_MEM_ARBITER_FIXED_PRIORITY_EN
  logic                       r_last_grant;
`endif
  logic [c_CNT_W-1:0]         r_count;
  logic [c_PTR_W-1:0]         r_wr_ptr;
  logic [c_PTR_W-1:0]         r_rd_ptr;
  logic [MAX_OUTSTANDING-1:0] r_tags;
  logic                       r_error;

  logic w_slot_free;
  logic w_elig0;
  logic w_elig1;
  logic w_gnt;
  logic w_gnt_valid;
  logic w_hs;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_head;

  // Slot availability looks only at the registered count; a same-cycle pop
  // does not open a slot until the following cycle.
  assign w_slot_free = (r_count < c_MAX_CNT);
  assign w_elig0     = req0_valid && (!req0_read_enable || w_slot_free);
  assign w_elig1     = req1_valid && (!req1_read_enable || w_slot_free);

  always_comb begin
    w_gnt = 1'b0;
    if (r_locked) begin
      w_gnt = r_lock_owner;
    end else if (w_elig0 && w_elig1) begin
`ifdef GECKO_MEM_ARBITER_FIXED_PRIORITY_EN
      w_gnt = 1'b0;
`else
      w_gnt = ~r_last_grant;
`endif
    end else if (w_elig1) begin
      w_gnt = 1'b1;
    end
  end

  assign w_gnt_valid = !rst && (w_gnt ? w_elig1 : w_elig0);

  always_comb begin
    mem_out_valid        = w_gnt_valid;
    mem_out_read_enable  = req0_read_enable;
    mem_out_write_enable = req0_write_enable;
    mem_out_addr         = req0_addr;
    mem_out_data         = req0_data;
    if (w_gnt) begin
      mem_out_read_enable  = req1_read_enable;
      mem_out_write_enable = req1_write_enable;
      mem_out_addr         = req1_addr;
      mem_out_data         = req1_data;
    end
  end

  assign req0_ready = w_gnt_valid && !w_gnt && mem_out_ready;
  assign req1_ready = w_gnt_valid &&  w_gnt && mem_out_ready;

  assign w_hs   = w_gnt_valid && mem_out_ready;
  assign w_push = w_hs && mem_out_read_enable;

  // Response routing: the FIFO head names the owner of the oldest read.
  assign w_empty = (r_count == '0);
  assign w_head  = r_tags[r_rd_ptr];

  always_comb begin
    resp0_valid    = 1'b0;
    resp1_valid    = 1'b0;
    mem_resp_ready = 1'b0;
    if (!rst) begin
      if (w_empty) begin
        mem_resp_ready = 1'b1;
      end else begin
        resp0_valid    = mem_resp_valid && !w_head;
        resp1_valid    = mem_resp_valid &&  w_head;
        mem_resp_ready = w_head ? resp1_ready : resp0_ready;
      end
    end
  end

  assign resp0_data = mem_resp_data;
  assign resp1_data = mem_resp_data;
  assign w_pop      = mem_resp_valid && mem_resp_ready && !w_empty;
  assign error      = r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked     <= 1'b0;
      r_lock_owner <= 1'b0;
    end else if (w_hs) begin
      r_locked     <= 1'b0;
    end else if (w_gnt_valid) begin
      r_locked     <= 1'b1;
      r_lock_owner <= w_gnt;
    end
  end

`ifndef GECKO_MEM_ARBITER_FIXED_PRIORITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_last_grant <= w_gnt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tags   <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_gnt;
        r_wr_ptr         <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (mem_resp_valid && w_empty) begin
      r_error <= 1'b1;
    end
  end

endmodule

`default_nettype wire
